neo_frame_sequencer: RTL and testbench
======================================

Name: neo_frame_sequencer

Overview:
Frame-level controller for the NEO datapath. On a start request it reads a frame of signed samples from the sample RAM, maintains the 3-sample window and computes psi[n] = x[n]^2 - x[n-1]*x[n+1] for every interior sample. Each result goes to the energy RAM with a start/busy/done handshake. It sits between the acquisition buffer (read port) and the energy buffer (write port). The host or detection logic triggers one frame per start.

Parameters:
N, 8, sample width (signed two's complement)
M, 16, frame buffer depth in samples; maximum frame length
AW, $clog2(M), RAM address width (derived, not overridden)

Ports:
Clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
len  in  AW+1  frame length in samples; valid range 3..M; sampled with start
busy  out  1  high from start acceptance until the done cycle, inclusive
done  out  1  one-cycle pulse at frame end
err  out  1  one-cycle pulse alongside done when len is out of range
ren  out  1  sample RAM read enable
raddr  out  AW  sample RAM read address
rdata  in  N  sample RAM read data; valid 1 cycle after ren/raddr
wen  out  1  energy RAM write enable
waddr  out  AW  energy RAM write address (= centre sample index)
wdata  out  2N+1  signed psi result

Behaviour:
- Reset: a synchronous reset (reset=1 at a rising Clk edge) forces state IDLE. All outputs become 0 and the window registers and counters are cleared. Reset mid-frame aborts the frame: no further ren/wen and no done.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: busy=0.
  - start=1 with 3<=len<=M: latch len, go to READ.
  - start=1 with len outside 3..M: go to DONE with err set; no ren/wen are ever issued.
- Cycle 0 is defined as the first READ cycle.
- READ: ren=1, raddr=0,1,...,len-1 in cycles 0..len-1, then go to DRAIN.
- Window: sample i arrives on rdata in cycle i+1 and shifts into the window (prev<=curr<=next<=rdata) at the end of that cycle. The window holds (j-1, j, j+1) during cycle j+2.
- Arithmetic:
  - Products are full 2N-bit signed.
  - The difference is 2N+1-bit signed, with no truncation or overflow over the full input range.
  - psi is computed combinationally from the window and registered into wdata.
- Write timing: result for centre j (1..len-2) appears with wen=1, waddr=j in cycle j+3, i.e. cycles 4..len+1. That is exactly len-2 writes. Indices 0 and len-1 are never written.
- DRAIN: ren=0; waits until the write for centre len-2 has been issued (cycle len+1), then goes to DONE.
- DONE: done=1 (and err=1 if invalid) for one cycle, busy=1 in that cycle, then return to IDLE.
  - Valid frame: done in cycle len+2.
  - Invalid len: done/err in the cycle after start.
- Outputs when not in use: wen=0 outside valid write cycles, and wdata holds its last value. raddr is 0 whenever ren=0.
- start while busy or in DONE: ignored, not queued. A new start is accepted on the first IDLE cycle after DONE.
- len=M: raddr reaches M-1 and the address counter must not wrap. len is AW+1 bits so M is representable.

Optional Feature:
NEO_CLAMP_EN
- Defined: a negative psi is replaced by 0 before registering; wdata is never negative.
- Undefined: wdata carries the raw signed psi.
- Timing and write count are identical in both builds.

Test Plan:
- Ramp frame: len=5, RAM=[1,2,3,2,1], start pulse -> ren cycles 0..4; writes (addr,data)=(1,1),(2,5),(3,1) in cycles 4,5,6; done=1, err=0 in cycle 7; busy low in cycle 8.
- Negative energy: len=3, RAM=[3,0,3] -> single write addr1 = -9 without NEO_CLAMP_EN, 0 with NEO_CLAMP_EN; done in cycle 5.
- Extremes (N=8): len=3, RAM=[-128,-128,127] -> addr1 = 16384 + 16256 = 32640, no overflow; RAM=[127,-128,127] -> 16384 - 16129 = 255.
- Invalid length: start with len=2, then with len=17 (M=16) -> done=1, err=1 in the next cycle; ren and wen stay 0.
- Full frame and busy start: len=16, start re-asserted every cycle while busy -> exactly 14 writes to addr 1..14; raddr never exceeds 15; one done. A start on the first IDLE cycle after done launches a second identical frame.
- Reset mid-frame: assert reset in cycle 6 of a len=10 frame -> next cycle all outputs 0, no further wen, no done. A start after reset runs a clean frame with correct results.

Source files
------------

// File: rtl/neo_frame_sequencer.sv
// Frame sequencer for the NEO datapath: reads a frame from the sample RAM and writes
// psi[n] = x[n]^2 - x[n-1]*x[n+1] to the energy RAM. Optional macro: NEO_CLAMP_EN.
module neo_frame_sequencer #(
    parameter  int N  = 8,
    parameter  int M  = 16,
    localparam int AW = $clog2(M)
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW:0]       len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ren,
    output logic [AW-1:0]     raddr,
    input  logic [N-1:0]      rdata,
    output logic              wen,
    output logic [AW-1:0]     waddr,
    output logic [2*N:0]      wdata
);

    localparam int CW = AW + 2;

    localparam logic [AW:0] LEN_MIN = (AW+1)'(3);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(M);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cyc;
    logic [AW:0]           r_len;
    logic                  r_err;
    logic signed [N-1:0]   r_prev;
    logic signed [N-1:0]   r_curr;
    logic                  r_wen;
    logic [AW-1:0]         r_waddr;
    logic [2*N:0]          r_wdata;

    logic                  w_len_ok;
    logic                  w_active;
    logic [CW-1:0]         w_len_x;
    logic                  w_last_rd;
    logic                  w_last_wr;
    logic                  w_calc;
    logic signed [N-1:0]   w_next;
    logic signed [2*N-1:0] w_sq;
    logic signed [2*N-1:0] w_xp;
    logic signed [2*N:0]   w_psi;
    logic signed [2*N:0]   w_psi_q;

    assign w_len_ok  = (len >= LEN_MIN) && (len <= LEN_MAX);
    assign w_active  = (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_len_x   = {1'b0, r_len};
    assign w_last_rd = (r_cyc == w_len_x - CW'(1));
    assign w_last_wr = (r_cyc == w_len_x + CW'(1));
    assign w_calc    = w_active && (r_cyc >= CW'(3)) && (r_cyc <= w_len_x);

    // The newest window sample is taken straight from rdata so centre j is
    // computed in cycle j+2 and lands on the write port in cycle j+3.
    assign w_next = rdata;
    assign w_sq   = r_curr * r_curr;
    assign w_xp   = r_prev * w_next;
    assign w_psi  = {w_sq[2*N-1], w_sq} - {w_xp[2*N-1], w_xp};

`ifdef NEO_CLAMP_EN
    assign w_psi_q = w_psi[2*N] ? '0 : w_psi;
`else
    assign w_psi_q = w_psi;
`endif

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
            r_prev  <= '0;
            r_curr  <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_active ? r_cyc + CW'(1) : '0;
            if (r_state == S_IDLE && start) begin
                r_len <= len;
                r_err <= !w_len_ok;
            end
            if (w_active) begin
                r_prev <= r_curr;
                r_curr <= w_next;
            end
            r_wen <= w_calc;
            if (w_calc) begin
                r_waddr <= AW'(r_cyc - CW'(2));
                r_wdata <= w_psi_q;
            end
        end
    end

    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        ren         = 1'b0;
        raddr       = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_len_ok ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                ren   = 1'b1;
                raddr = r_cyc[AW-1:0];
                if (w_last_rd) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_wr) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign err   = (r_state == S_DONE) && r_err;
    assign wen   = r_wen;
    assign waddr = r_waddr;
    assign wdata = r_wdata;

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Self-checking bench for neo_frame_sequencer: directed vector table, randomized frames
// against an arithmetic reference model, and reset-abort / back-to-back sequences.
module tb_neo_frame_sequencer;

    localparam int N  = 8;
    localparam int M  = 16;
    localparam int AW = $clog2(M);

    logic          Clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   len;
    logic          busy, done, err, ren, wen;
    logic [AW-1:0] raddr, waddr;
    logic [N-1:0]  rdata;
    logic [2*N:0]  wdata;

    logic signed [N-1:0] mem [M];

    int n_vec = 0;
    int n_err = 0;

    neo_frame_sequencer #(.N(N), .M(M)) dut (
        .Clk   (Clk),
        .reset (reset),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata)
    );

    always #5 Clk = ~Clk;

    // Sample RAM: one-cycle read latency.
    always @(posedge Clk) begin
        if (ren) rdata <= mem[raddr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    typedef struct {
        int flen;
        int smp[16];
        bit hold;
        bit exp_err;
        int exp_writes;
        int exp_done;
        int exp_psi1;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int psi_model(input int j);
        int a, b, c, v;
        a = mem[j-1];
        b = mem[j];
        c = mem[j+1];
        v = b * b - a * c;
`ifdef NEO_CLAMP_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    // Called at #1 after an edge with the DUT idle; the next edge accepts start.
    // Returns at #1 into the first IDLE cycle after DONE, start left as the caller set it.
    task automatic run_frame(input int flen, input bit hold,
                             output int writes, output int done_cyc,
                             output int psi1, output int err_seen);
        bit valid;
        bit got_done;
        bit exp_ren, exp_wen, exp_done;
        int c;
        valid    = (flen >= 3) && (flen <= M);
        writes   = 0;
        done_cyc = -1;
        psi1     = 0;
        err_seen = 0;
        got_done = 1'b0;
        start    = 1'b1;
        len      = (AW+1)'(flen);
        @(posedge Clk); #1;
        if (!hold) start = 1'b0;
        c = 0;
        while (!got_done && c < 40) begin
            exp_ren  = valid && (c <= flen - 1);
            exp_wen  = valid && (c >= 4) && (c <= flen + 1);
            exp_done = valid ? (c == flen + 2) : (c == 0);
            check("ren", int'(ren), int'(exp_ren));
            check("raddr", int'(raddr), exp_ren ? c : 0);
            check("wen", int'(wen), int'(exp_wen));
            if (exp_wen) begin
                check("waddr", int'(waddr), c - 3);
                check("wdata", int'($signed(wdata)), psi_model(c - 3));
            end
            check("busy", int'(busy), 1);
            check("done", int'(done), int'(exp_done));
            check("err", int'(err), int'(exp_done && !valid));
            if (wen) writes++;
            if (wen && waddr == 1) psi1 = int'($signed(wdata));
            if (err) err_seen = 1;
            if (done) begin
                done_cyc = c;
                got_done = 1'b1;
            end else begin
                @(posedge Clk); #1;
                c++;
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        @(posedge Clk); #1;
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_wen", int'(wen), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int w, d, p, e, flen, wen_seen, done_seen;
        bit valid;

        vecs[0] = '{5,  '{1,2,3,2,1,0,0,0,0,0,0,0,0,0,0,0}, 1'b0, 1'b0, 3, 7, 1};
`ifdef NEO_CLAMP_EN
        vecs[1] = '{3,  '{3,0,3,0,0,0,0,0,0,0,0,0,0,0,0,0}, 1'b0, 1'b0, 1, 5, 0};
`else
        vecs[1] = '{3,  '{3,0,3,0,0,0,0,0,0,0,0,0,0,0,0,0}, 1'b0, 1'b0, 1, 5, -9};
`endif
        vecs[2] = '{3,  '{-128,-128,127,0,0,0,0,0,0,0,0,0,0,0,0,0}, 1'b0, 1'b0, 1, 5, 32640};
        vecs[3] = '{3,  '{127,-128,127,0,0,0,0,0,0,0,0,0,0,0,0,0}, 1'b0, 1'b0, 1, 5, 255};
        vecs[4] = '{2,  '{9,9,9,0,0,0,0,0,0,0,0,0,0,0,0,0}, 1'b0, 1'b1, 0, 0, 0};
        vecs[5] = '{17, '{9,9,9,0,0,0,0,0,0,0,0,0,0,0,0,0}, 1'b0, 1'b1, 0, 0, 0};
        vecs[6] = '{16, '{-8,-7,-6,-5,-4,-3,-2,-1,0,1,2,3,4,5,6,7}, 1'b1, 1'b0, 14, 18, 1};

        reset = 1'b1;
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < M; i++) mem[i] = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ren", int'(ren), 0);
        check("rst_raddr", int'(raddr), 0);
        check("rst_wen", int'(wen), 0);
        check("rst_wdata", int'(wdata), 0);
        reset = 1'b0;

        // Directed table; the held-start entry chains a second identical frame.
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < M; i++) mem[i] = N'(vecs[k].smp[i]);
            for (int r = 0; r < (vecs[k].hold ? 2 : 1); r++) begin
                run_frame(vecs[k].flen, vecs[k].hold, w, d, p, e);
                check("tbl_writes", w, vecs[k].exp_writes);
                check("tbl_done_cyc", d, vecs[k].exp_done);
                check("tbl_err", e, int'(vecs[k].exp_err));
                if (vecs[k].exp_writes > 0) check("tbl_psi1", p, vecs[k].exp_psi1);
            end
            start = 1'b0;
        end

        // Randomized frames against the arithmetic model.
        for (int t = 0; t < 30; t++) begin
            if (t % 6 == 5) flen = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(17, 31);
            else            flen = $urandom_range(3, M);
            valid = (flen >= 3) && (flen <= M);
            for (int i = 0; i < M; i++) begin
                case ($urandom_range(0, 5))
                    0:       mem[i] = -8'sd128;
                    1:       mem[i] = 8'sd127;
                    default: mem[i] = N'($urandom_range(0, 255));
                endcase
            end
            run_frame(flen, 1'($urandom_range(0, 1)), w, d, p, e);
            check("rnd_writes", w, valid ? flen - 2 : 0);
            check("rnd_done_cyc", d, valid ? flen + 2 : 0);
            check("rnd_err", e, valid ? 0 : 1);
            start = 1'b0;
        end

        // Reset in cycle 6 of a len=10 frame aborts it.
        for (int i = 0; i < M; i++) mem[i] = N'(i * 3 - 7);
        start = 1'b1;
        len   = (AW+1)'(10);
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge Clk); #1;
        end
        reset = 1'b1;
        @(posedge Clk); #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        check("abort_ren", int'(ren), 0);
        check("abort_raddr", int'(raddr), 0);
        check("abort_wen", int'(wen), 0);
        check("abort_waddr", int'(waddr), 0);
        check("abort_wdata", int'(wdata), 0);
        reset     = 1'b0;
        wen_seen  = 0;
        done_seen = 0;
        repeat (15) begin
            @(posedge Clk); #1;
            if (wen) wen_seen++;
            if (done) done_seen++;
        end
        check("abort_no_wen", wen_seen, 0);
        check("abort_no_done", done_seen, 0);
        run_frame(10, 1'b0, w, d, p, e);
        check("post_rst_writes", w, 8);
        check("post_rst_done_cyc", d, 12);
        check("post_rst_psi1", p, psi_model(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
